// File: rtl/rob.sv
// rob: reorder buffer with in-order retire and branch resolution.
// Frees pd_old at retire; turns branch results into mispredict/hit pulses.
module rob #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [PREG_W-1:0] pd_new,
  input  logic [PREG_W-1:0] pd_old,
  input  logic [$clog2(DEPTH)-1:0] rob_tag_in,
  input  logic              is_branch,
  input  logic [31:0]       pc_in,
  input  logic              cmpl_valid,
  input  logic [$clog2(DEPTH)-1:0] cmpl_tag,
  input  logic              br_valid,
  input  logic [$clog2(DEPTH)-1:0] br_tag,
  input  logic              br_mispredict,
  output logic              write_en,
  output logic [PREG_W-1:0] rob_data_out,
  output logic              mispredict,
  output logic [$clog2(DEPTH):0] mispredict_tag,
  output logic              hit,
  output logic [31:0]       commit_pc,
  output logic              empty
);
  localparam int TW = $clog2(DEPTH);
  localparam logic [TW:0]   FULL = (TW+1)'(DEPTH);
  localparam logic [TW:0]   C1 = 1;
  localparam logic [TW-1:0] T1 = 1;

  logic [DEPTH-1:0]  valid_q, done_q, isbr_q;
  logic [PREG_W-1:0] pdold_q [DEPTH];
  logic [31:0]       pc_q [DEPTH];
  logic [TW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [TW:0]       count_q, count_d, mis_cnt;
  logic              we_q, mis_q, hit_q;
  logic [PREG_W-1:0] data_q;
  logic [31:0]       cpc_q;
  logic [TW:0]       mtag_q;

  logic              br_ok, mis_now, flush_block, disp, ret;
  logic [TW-1:0]     br_age;
  logic [DEPTH-1:0]  squash;

  // rename keeps pd_new itself; the ROB only needs pd_old to free
  logic unused_pd_new;
  assign unused_pd_new = ^pd_new;

  assign br_ok       = br_valid && valid_q[br_tag] && isbr_q[br_tag];
  assign mis_now     = br_ok && br_mispredict;
  assign flush_block = mis_now || mis_q;
  assign ready_in    = (count_q != FULL) && !flush_block;
  assign disp        = valid_in && ready_in;
  assign ret         = valid_q[head_q] && done_q[head_q];
  assign br_age      = br_tag - head_q;
  // age 0..15 plus the branch itself gives 1..16 surviving entries
  assign mis_cnt     = {1'b0, br_age} + C1;

  // entries strictly younger than the mispredicted branch
  always_comb begin
    squash = '0;
    for (int i = 0; i < DEPTH; i++)
      squash[i] = mis_now && ((TW'(i) - head_q) > br_age);
  end

  // pointer and occupancy next-state
  always_comb begin
    head_d  = ret ? head_q + T1 : head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mis_now) begin
      tail_d  = br_tag + T1;
      count_d = mis_cnt;
    end else if (disp) begin
      tail_d  = rob_tag_in + T1;
      count_d = count_q + C1;
    end
    if (ret)
      count_d = count_d - C1;
  end

  // per-entry valid/done/branch flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      done_q  <= '0;
      isbr_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (disp && rob_tag_in == TW'(i)) begin
          valid_q[i] <= 1'b1;
          done_q[i]  <= 1'b0;
          isbr_q[i]  <= is_branch;
        end else if (squash[i] || (ret && head_q == TW'(i))) begin
          valid_q[i] <= 1'b0;
        end else if ((cmpl_valid && cmpl_tag == TW'(i) && valid_q[i])
                     || (br_ok && br_tag == TW'(i))) begin
          done_q[i] <= 1'b1;
        end
      end
    end
  end

  // entry payload, qualified by valid so no reset needed
  always_ff @(posedge clk) begin
    if (disp) begin
      pdold_q[rob_tag_in] <= pd_old;
      pc_q[rob_tag_in]    <= pc_in;
    end
  end

  // pointers and registered retire/branch outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      cpc_q   <= '0;
      mis_q   <= 1'b0;
      hit_q   <= 1'b0;
      mtag_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= ret && (pdold_q[head_q] != '0);
      if (ret) begin
        data_q <= pdold_q[head_q];
        cpc_q  <= pc_q[head_q];
      end
      mis_q <= mis_now;
      hit_q <= br_ok && !br_mispredict;
      if (br_ok)
        mtag_q <= {1'b0, br_tag};
    end
  end

  // rename must hand out tags in tail order
  a_tag_is_tail: assert property (@(posedge clk) disable iff (reset)
    disp |-> rob_tag_in == tail_q);

  assign write_en       = we_q;
  assign rob_data_out   = data_q;
  assign commit_pc      = cpc_q;
  assign mispredict     = mis_q;
  assign hit            = hit_q;
  assign mispredict_tag = mtag_q;
  assign empty          = (count_q == '0);
endmodule

// File: tb/tb_rob.sv
// tb_rob: randomized scoreboard bench for the reorder buffer.
// A program-order queue model predicts retires, pulses and readiness.
module tb_rob;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, ready_in, is_branch;
  logic [6:0]  pd_new, pd_old, rob_data_out;
  logic [3:0]  rob_tag_in, cmpl_tag, br_tag;
  logic [31:0] pc_in, commit_pc;
  logic        cmpl_valid, br_valid, br_mispredict;
  logic        write_en, mispredict, hit, empty;
  logic [4:0]  mispredict_tag;

  rob #(.DEPTH(16), .PREG_W(7)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .ready_in(ready_in),
    .pd_new(pd_new), .pd_old(pd_old),
    .rob_tag_in(rob_tag_in), .is_branch(is_branch),
    .pc_in(pc_in), .cmpl_valid(cmpl_valid),
    .cmpl_tag(cmpl_tag), .br_valid(br_valid),
    .br_tag(br_tag), .br_mispredict(br_mispredict),
    .write_en(write_en), .rob_data_out(rob_data_out),
    .mispredict(mispredict),
    .mispredict_tag(mispredict_tag), .hit(hit),
    .commit_pc(commit_pc), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [6:0]  po;
    logic [31:0] pc;
    bit          br;
    bit          done;
  } ent_t;
  typedef struct {
    logic [3:0]  tag;
    logic [6:0]  po;
    logic [31:0] pc;
  } wb_t;
  typedef struct {
    bit         m;
    logic [3:0] t;
  } br_t;

  ent_t       mq[$];
  wb_t        wbq[$];
  br_t        brq[$];
  logic [3:0] tail_m;
  bit         mis_prev;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // monitor: pop expectations whenever the DUT presents an event
  wb_t mw;
  br_t mb;
  always @(negedge clk) begin
    if (!reset) begin
      if (write_en) begin
        if (wbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_spurious act=%0d exp=none", rob_data_out);
        end else begin
          mw = wbq.pop_front();
          chk("wb_data", rob_data_out, mw.po);
          chk("wb_pc", commit_pc, mw.pc);
        end
      end
      if (hit || mispredict) begin
        if (brq.size() == 0) begin
          checks++; errors++;
          $display("FAIL br_spurious act=%0b%0b exp=none", hit, mispredict);
        end else begin
          mb = brq.pop_front();
          chk("br_mis", mispredict, mb.m);
          chk("br_hit", hit, !mb.m);
          chk("br_tag", mispredict_tag, {1'b0, mb.t});
        end
      end
    end
  end

  task automatic clr_in();
    valid_in = 0; pd_new = 0; pd_old = 0; rob_tag_in = 0;
    is_branch = 0; pc_in = 0; cmpl_valid = 0; cmpl_tag = 0;
    br_valid = 0; br_tag = 0; br_mispredict = 0;
  endtask

  task automatic model_reset();
    mq.delete(); wbq.delete(); brq.delete();
    tail_m = 0; mis_prev = 0;
  endtask

  task automatic chk_reset();
    chk("rst_ready", ready_in, 1);
    chk("rst_empty", empty, 1);
    chk("rst_we", write_en, 0);
    chk("rst_data", rob_data_out, 0);
    chk("rst_mis", mispredict, 0);
    chk("rst_hit", hit, 0);
    chk("rst_mtag", mispredict_tag, 0);
    chk("rst_pc", commit_pc, 0);
  endtask

  // one cycle: drive inputs, check readiness, advance model
  task automatic step(bit dv, logic [6:0] po, bit ib, bit cv,
                      logic [3:0] ct, bit bv, logic [3:0] bt, bit bm);
    int k;
    bit mis_now, er, ret;
    logic [31:0] pc;
    logic [15:0] sq;
    ent_t e;
    wb_t w;
    @(negedge clk);
    k = -1;
    foreach (mq[j]) if (mq[j].tag == bt && mq[j].br) k = j;
    mis_now = bv && bm && (k >= 0);
    er = (mq.size() < 16) && !mis_prev && !mis_now;
    pc = $urandom;
    valid_in = dv; pd_new = 7'($urandom); pd_old = po;
    rob_tag_in = tail_m; is_branch = ib; pc_in = pc;
    cmpl_valid = cv; cmpl_tag = ct;
    br_valid = bv; br_tag = bt; br_mispredict = bm;
    #1;
    chk("ready_in", ready_in, er);
    chk("empty", empty, mq.size() == 0);
    ret = (mq.size() > 0) && mq[0].done;
    if (cv) foreach (mq[j]) if (mq[j].tag == ct) mq[j].done = 1;
    if (bv && k >= 0) begin
      brq.push_back('{bm, bt});
      mq[k].done = 1;
      if (bm) begin
        sq = '0;
        while (mq.size() > k + 1) begin
          e = mq.pop_back();
          sq[e.tag] = 1'b1;
        end
        while (wbq.size() > 0 && sq[wbq[$].tag]) w = wbq.pop_back();
        tail_m = bt + 4'd1;
      end
    end
    if (ret) e = mq.pop_front();
    if (dv && er) begin
      mq.push_back('{tail_m, po, pc, ib, 1'b0});
      if (po != 0) wbq.push_back('{tail_m, po, pc});
      tail_m = tail_m + 4'd1;
    end
    mis_prev = mis_now;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // complete everything outstanding, then check nothing is left over
  task automatic drain();
    int g, j;
    g = 0;
    while (mq.size() > 0 && g < 300) begin
      j = -1;
      foreach (mq[x]) if (j < 0 && !mq[x].done) j = x;
      if (j < 0) idle(1);
      else if (mq[j].br) step(0, 0, 0, 0, 0, 1, mq[j].tag, 0);
      else step(0, 0, 0, 1, mq[j].tag, 0, 0, 0);
      g++;
    end
    if (mq.size() != 0) chk("drain_timeout", mq.size(), 0);
    idle(4);
    chk("wbq_left", wbq.size(), 0);
    chk("brq_left", brq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  bit         dv, ib, cv, bv, bm;
  logic [6:0] po;
  logic [3:0] ct, bt, t0;
  int         j;

  initial begin
    clr_in();
    model_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    chk_reset();
    reset = 0;

    // tags 0..3, complete out of order
    for (int i = 0; i < 4; i++) step(1, 7'(8 + i), 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    idle(4);
    chk("inorder_left", wbq.size(), 0);
    chk("inorder_empty", empty, 1);

    // pd_old = 0 must not pulse write_en
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, tail_m - 4'd1, 0, 0, 0);
    idle(3);

    // fill to 16, then one retire reopens a cycle later
    t0 = tail_m;
    for (int i = 0; i < 17; i++)
      step(1, 7'($urandom_range(1, 127)), 0, 0, 0, 0, 0, 0);
    step(1, 7'd33, 0, 1, t0, 0, 0, 0);
    step(1, 7'd34, 0, 0, 0, 0, 0, 0);
    step(1, 7'd35, 0, 0, 0, 0, 0, 0);
    drain();

    // mispredict on second of five squashes the last three
    t0 = tail_m;
    for (int i = 0; i < 5; i++)
      step(1, 7'(20 + i), i == 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, t0 + 4'd1, 1);
    step(1, 7'd40, 0, 0, 0, 0, 0, 0);
    chk("mis_tail", tail_m, t0 + 4'd2);
    step(1, 7'd41, 0, 0, 0, 0, 0, 0);
    chk("post_mis_tail", tail_m, t0 + 4'd3);
    drain();

    // correctly predicted branch: hit, nothing squashed
    t0 = tail_m;
    step(1, 7'd50, 1, 0, 0, 0, 0, 0);
    step(1, 7'd51, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, t0, 0);
    chk("hit_count", mq.size(), 2);
    drain();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      dv = ($urandom % 3) != 0;
      po = ($urandom % 4 == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      ib = ($urandom % 5) == 0;
      cv = 0; ct = 0;
      if (mq.size() > 0 && $urandom % 2 == 1) begin
        j = int'($urandom % mq.size());
        if (!mq[j].br) begin cv = 1; ct = mq[j].tag; end
      end else if ($urandom % 16 == 0) begin
        cv = 1; ct = 4'($urandom);
      end
      bv = 0; bt = 0; bm = 0;
      if ($urandom % 4 == 0) begin
        foreach (mq[x])
          if (mq[x].br && !mq[x].done && (!bv || $urandom % 2 == 1)) begin
            bv = 1; bt = mq[x].tag;
          end
        bm = ($urandom % 2) == 1;
      end else if ($urandom % 20 == 0) begin
        bv = 1; bt = 4'($urandom); bm = ($urandom % 2) == 1;
      end
      step(dv, po, ib, cv, ct, bv, bt, bm);
    end
    drain();

    // reset while a completed head is about to retire
    step(1, 7'd5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, tail_m - 4'd1, 0, 0, 0);
    @(negedge clk);
    #2 reset = 1;
    #1 chk_reset();
    clr_in();
    model_reset();
    @(negedge clk);
    reset = 0;
    idle(3);
    step(1, 7'd9, 0, 0, 0, 0, 0, 0);
    chk("rst_tail", tail_m, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
